gate_truth_checker: RTL and testbench

- Stimulus/response end of a 2-input gate interface: drives `i0`/`i1` into a gate under test and reads back its `o`.
- Sweeps all four input combinations in order, waits a programmable settle time, samples the output and compares it against an expected truth table.
- Reports pass/fail, a per-vector failure mask and an error count.
- Sits beside the lab gate modules as the self-check harness for board or bench use.

---
 rtl/gate_truth_checker.sv | 137 +++++++++++++
 tb/tb_gate_truth_checker.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_checker.sv
// Self-check harness for a 2-input gate: sweeps {i0,i1} = 00..11, waits a
// settle time per vector, samples the gate output and scores it against EXPECT.
module gate_truth_checker #(
    parameter logic [3:0] EXPECT = 4'b0111,
    parameter int         SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_o,
    output logic       dut_i0,
    output logic       dut_i1,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [2:0] err_count
);

    // Out-of-range settle values are clamped into 1..255.
    localparam int SETTLE_EFF =
        (SETTLE < 1) ? 1 : ((SETTLE > 255) ? 255 : SETTLE);
    localparam logic [7:0] LAST_CNT = 8'(SETTLE_EFF - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_vec;
    logic [7:0] r_cnt;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [3:0] r_mask;
    logic [2:0] r_err;

    logic       w_mismatch;
    logic       w_settled;
    logic       w_last_vec;

    // Case-inequality so an undriven gate output is scored as a mismatch.
    assign w_mismatch = (dut_o !== EXPECT[r_vec]);
    assign w_settled  = (r_cnt == LAST_CNT);
    assign w_last_vec = (r_vec == 2'd3);

    assign dut_i0    = r_vec[1];
    assign dut_i1    = r_vec[0];
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_mask = r_mask;
    assign err_count = r_err;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: idle until start, settle each vector, one check cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_settled) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                w_next = w_last_vec ? S_IDLE : S_WAIT;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Vector/counter stepping and result accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec  <= 2'd0;
            r_cnt  <= 8'd0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
            r_mask <= 4'd0;
            r_err  <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_vec  <= 2'd0;
                        r_cnt  <= 8'd0;
                        r_busy <= 1'b1;
                        r_done <= 1'b0;
                        r_pass <= 1'b0;
                        r_mask <= 4'd0;
                        r_err  <= 3'd0;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                end
                S_CHECK: begin
                    if (w_mismatch) begin
                        r_mask[r_vec] <= 1'b1;
                        r_err         <= r_err + 3'd1;
                    end
                    if (w_last_vec) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_pass <= (r_mask == 4'd0) && !w_mismatch;
                    end else begin
                        r_vec <= r_vec + 2'd1;
                        r_cnt <= 8'd0;
                    end
                end
                default: begin
                    r_cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Scoreboard bench for gate_truth_checker: stimulus pushes expected sweep
// results, a monitor pops and compares on each rising done.
module tb_gate_truth_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] st;
    logic [4:0] bsy;
    logic [4:0] dn;
    logic [4:0] ps;
    logic [4:0] di0;
    logic [4:0] di1;
    logic [4:0] dout;
    logic [3:0] fm [5];
    logic [2:0] ec [5];
    logic [1:0] m0;

    // Settling-gate history: output is wrong until inputs held 2 edges.
    logic [1:0] h1a, h2a, h1b, h2b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         id;
        logic [3:0] mask;
        logic [2:0] err;
        logic       pass;
        int         cycles;
    } exp_t;

    exp_t q[$];

    int seff[5] = '{2, 2, 1, 3, 1};

    // u0: NAND expected, model selectable (0 NAND, 1 stuck-1, 2 AND)
    gate_truth_checker #(.EXPECT(4'b0111), .SETTLE(2)) u0 (
        .clk(clk), .rst(rst), .start(st[0]), .dut_o(dout[0]),
        .dut_i0(di0[0]), .dut_i1(di1[0]), .busy(bsy[0]), .done(dn[0]),
        .pass(ps[0]), .fail_mask(fm[0]), .err_count(ec[0]));

    // u1: AND gate against an AND truth table
    gate_truth_checker #(.EXPECT(4'b1000), .SETTLE(2)) u1 (
        .clk(clk), .rst(rst), .start(st[1]), .dut_o(dout[1]),
        .dut_i0(di0[1]), .dut_i1(di1[1]), .busy(bsy[1]), .done(dn[1]),
        .pass(ps[1]), .fail_mask(fm[1]), .err_count(ec[1]));

    // u2: slow NAND, settle too short
    gate_truth_checker #(.EXPECT(4'b0111), .SETTLE(1)) u2 (
        .clk(clk), .rst(rst), .start(st[2]), .dut_o(dout[2]),
        .dut_i0(di0[2]), .dut_i1(di1[2]), .busy(bsy[2]), .done(dn[2]),
        .pass(ps[2]), .fail_mask(fm[2]), .err_count(ec[2]));

    // u3: slow NAND, settle long enough
    gate_truth_checker #(.EXPECT(4'b0111), .SETTLE(3)) u3 (
        .clk(clk), .rst(rst), .start(st[3]), .dut_o(dout[3]),
        .dut_i0(di0[3]), .dut_i1(di1[3]), .busy(bsy[3]), .done(dn[3]),
        .pass(ps[3]), .fail_mask(fm[3]), .err_count(ec[3]));

    // u4: SETTLE=0 must behave as SETTLE=1
    gate_truth_checker #(.EXPECT(4'b0111), .SETTLE(0)) u4 (
        .clk(clk), .rst(rst), .start(st[4]), .dut_o(dout[4]),
        .dut_i0(di0[4]), .dut_i1(di1[4]), .busy(bsy[4]), .done(dn[4]),
        .pass(ps[4]), .fail_mask(fm[4]), .err_count(ec[4]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h1a <= 2'b00;
            h2a <= 2'b00;
            h1b <= 2'b00;
            h2b <= 2'b00;
        end else begin
            h1a <= {di0[2], di1[2]};
            h2a <= h1a;
            h1b <= {di0[3], di1[3]};
            h2b <= h1b;
        end
    end

    always_comb begin
        dout = 5'b0;
        case (m0)
            2'd0:    dout[0] = ~(di0[0] & di1[0]);
            2'd1:    dout[0] = 1'b1;
            default: dout[0] = di0[0] & di1[0];
        endcase
        dout[1] = di0[1] & di1[1];
        dout[2] = ~(di0[2] & di1[2]);
        if (!(({di0[2], di1[2]} == h1a) && (h1a == h2a)))
            dout[2] = ~dout[2];
        dout[3] = ~(di0[3] & di1[3]);
        if (!(({di0[3], di1[3]} == h1b) && (h1b == h2b)))
            dout[3] = ~dout[3];
        dout[4] = ~(di0[4] & di1[4]);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: step sequence tracking plus scoreboard pop on done rising.
    initial begin : monitor
        int         bc[5];
        int         bad[5];
        logic [4:0] pdn;
        exp_t       e;
        logic [1:0] want;
        for (int i = 0; i < 5; i++) begin
            bc[i]  = 0;
            bad[i] = 0;
        end
        pdn = 5'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int i = 0; i < 5; i++) begin
                    bc[i]  = 0;
                    bad[i] = 0;
                end
                pdn = 5'b0;
            end else begin
                for (int i = 0; i < 5; i++) begin
                    if (bsy[i]) begin
                        want = 2'(bc[i] / (seff[i] + 1));
                        if ({di0[i], di1[i]} != want) bad[i]++;
                        bc[i]++;
                    end
                    if (dn[i] && !pdn[i]) begin
                        if (q.size() == 0) begin
                            chk($sformatf("u%0d unexpected_done", i), 1, 0);
                        end else begin
                            e = q.pop_front();
                            chk($sformatf("u%0d inst", i), i, e.id);
                            chk($sformatf("u%0d fail_mask", i),
                                int'(fm[i]), int'(e.mask));
                            chk($sformatf("u%0d err_count", i),
                                int'(ec[i]), int'(e.err));
                            chk($sformatf("u%0d pass", i),
                                int'(ps[i]), int'(e.pass));
                            chk($sformatf("u%0d busy_cycles", i),
                                bc[i], e.cycles);
                            chk($sformatf("u%0d step_errors", i), bad[i], 0);
                            chk($sformatf("u%0d final_inputs", i),
                                int'({di0[i], di1[i]}), 3);
                        end
                        bc[i]  = 0;
                        bad[i] = 0;
                    end
                    pdn[i] = dn[i];
                end
            end
        end
    end

    task automatic push(input int id, input logic [3:0] mask,
                        input logic [2:0] err, input logic p,
                        input int cyc);
        exp_t e;
        e.id     = id;
        e.mask   = mask;
        e.err    = err;
        e.pass   = p;
        e.cycles = cyc;
        q.push_back(e);
    endtask

    task automatic wait_done(input int id);
        int n = 0;
        while (!dn[id] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!dn[id]) chk($sformatf("u%0d done_timeout", id), 0, 1);
        @(negedge clk);
    endtask

    task automatic run_sweep(input int id, input logic [3:0] mask,
                             input logic [2:0] err, input logic p,
                             input int cyc);
        push(id, mask, err, p, cyc);
        @(negedge clk);
        st[id] = 1'b1;
        @(negedge clk);
        st[id] = 1'b0;
        wait_done(id);
    endtask

    task automatic check_idle_zero(input int i, input string tag);
        chk($sformatf("%s u%0d busy", tag, i), int'(bsy[i]), 0);
        chk($sformatf("%s u%0d done", tag, i), int'(dn[i]), 0);
        chk($sformatf("%s u%0d pass", tag, i), int'(ps[i]), 0);
        chk($sformatf("%s u%0d mask", tag, i), int'(fm[i]), 0);
        chk($sformatf("%s u%0d err", tag, i), int'(ec[i]), 0);
        chk($sformatf("%s u%0d inputs", tag, i),
            int'({di0[i], di1[i]}), 0);
    endtask

    initial begin : stim
        int   n;
        int   rises;
        logic pd;
        rst = 1'b1;
        st  = 5'b0;
        m0  = 2'd0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) check_idle_zero(i, "reset");
        rst = 1'b0;
        @(negedge clk);

        run_sweep(0, 4'b0000, 3'd0, 1'b1, 12);
        m0 = 2'd1;
        run_sweep(0, 4'b1000, 3'd1, 1'b0, 12);
        m0 = 2'd2;
        run_sweep(0, 4'b1111, 3'd4, 1'b0, 12);
        run_sweep(1, 4'b0000, 3'd0, 1'b1, 12);
        run_sweep(2, 4'b1110, 3'd3, 1'b0, 8);
        run_sweep(3, 4'b0000, 3'd0, 1'b1, 16);
        run_sweep(4, 4'b0000, 3'd0, 1'b1, 8);

        // start pulsed again mid-sweep must be ignored
        m0 = 2'd0;
        push(0, 4'b0000, 3'd0, 1'b1, 12);
        @(negedge clk);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (4) @(negedge clk);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        wait_done(0);

        // start held: two back-to-back sweeps, done high one cycle between
        push(0, 4'b0000, 3'd0, 1'b1, 12);
        push(0, 4'b0000, 3'd0, 1'b1, 12);
        @(negedge clk);
        st[0] = 1'b1;
        rises = 0;
        pd    = 1'b0;
        n     = 0;
        while (rises < 2 && n < 200) begin
            @(negedge clk);
            n++;
            if (dn[0] && !pd) begin
                rises++;
                if (rises == 2) st[0] = 1'b0;
            end else if (pd && rises == 1) begin
                chk("b2b done_width", int'(dn[0]), 0);
                chk("b2b restart_busy", int'(bsy[0]), 1);
            end
            pd = dn[0];
        end
        st[0] = 1'b0;
        if (rises < 2) chk("b2b done_timeout", rises, 2);
        @(negedge clk);

        // async reset during WAIT of vector 2
        @(negedge clk);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        n = 0;
        while (!(di0[0] && !di1[0]) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("abort reached_vec2", int'({di0[0], di1[0]}), 2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_idle_zero(0, "abort");
        @(negedge clk);
        rst = 1'b0;
        run_sweep(0, 4'b0000, 3'd0, 1'b1, 12);

        @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
